// File: rtl/inst_sram_responder_pkg.sv
// Shared widths and types for the instruction SRAM-like responder.
package inst_sram_responder_pkg;

  localparam int unsigned BUS_W      = 32;
  localparam int unsigned WORD_SHIFT = 2;

  typedef logic [BUS_W-1:0] word_t;

endpackage

// File: rtl/inst_sram_responder_resp_fifo.sv
// In-order response buffer: DEPTH x 32 FIFO, registered storage, async active-high reset.
module resp_fifo
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  word_t wdata,
  output word_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  word_t          mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= wdata;
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  pop_when_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/inst_sram_responder.sv
// Responder end of the SRAM-like instruction bus: credit-limited accept, fixed-latency
// RAM read, in-order buffered return with hold back-pressure.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [BUS_W-1:0]  inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [BUS_W-1:0]  inst_rdata,
  input  logic              resp_hold,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [BUS_W-1:0]  ram_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]       cnt;
  logic [RAM_LATENCY-1:0] pipe;
  logic                   hs;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  word_t                  head;
  logic                   unused_bits;

  // Credit check uses the registered count only, so a same-cycle pop frees nothing yet.
  assign inst_addr_ok = inst_req && !reset && (cnt < CNT_W'(DEPTH));
  assign hs           = inst_req && inst_addr_ok;
  assign ram_en       = hs;
  assign ram_addr     = reset ? '0 : inst_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];

  assign push         = pipe[RAM_LATENCY-1];
  assign pop          = !fifo_empty && !resp_hold;
  assign inst_data_ok = pop;
  assign inst_rdata   = head;
  assign busy         = (cnt != '0);

  assign unused_bits  = ^{inst_addr[BUS_W-1:ADDR_W+WORD_SHIFT],
                          inst_addr[WORD_SHIFT-1:0], fifo_full};

  // Valid bit per RAM pipeline stage; the last stage marks ram_rdata as this cycle's data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= hs;
      for (int i = 1; i < int'(RAM_LATENCY); i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Outstanding count covers both the RAM pipe and buffered responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({hs, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  resp_fifo #(
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (ram_rdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_inst_sram_responder.sv
// Randomized bench for inst_sram_responder at RAM_LATENCY 1 and 3 against a queue-based
// model of outstanding responses, plus a few hand-computed pins.
module tb_inst_sram_responder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;

  typedef struct {
    logic [31:0] data;
    int          ready;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req;
  logic                   hold;
  logic [31:0]            addr;
  logic [1:0]             addr_ok;
  logic [1:0]             data_ok;
  logic [1:0]             ram_en;
  logic [1:0]             busy;
  logic [1:0][31:0]       rdata;
  logic [1:0][31:0]       ram_rdata;
  logic [1:0][ADDR_W-1:0] ram_addr;
  logic [31:0]            mem [1<<ADDR_W];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int lat, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s lat=%0d cyc=%0d got=%h want=%h", name, lat, cyc, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] rd_pipe [LAT];
    exp_t        q [$];

    inst_sram_responder #(
      .DEPTH       (DEPTH),
      .RAM_LATENCY (LAT),
      .ADDR_W      (ADDR_W)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (req),
      .inst_addr    (addr),
      .inst_addr_ok (addr_ok[g]),
      .inst_data_ok (data_ok[g]),
      .inst_rdata   (rdata[g]),
      .resp_hold    (hold),
      .ram_en       (ram_en[g]),
      .ram_addr     (ram_addr[g]),
      .ram_rdata    (ram_rdata[g]),
      .busy         (busy[g])
    );

    // Synchronous RAM with fixed latency; garbage when not enabled.
    always @(posedge clk) begin
      rd_pipe[0] <= ram_en[g] ? mem[ram_addr[g]] : $urandom;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata[g] = rd_pipe[LAT-1];

    // Model: queue of accepted requests, each due LAT+1 cycles after acceptance.
    always @(negedge clk) begin
      logic        eok;
      logic        edok;
      logic [11:0] word;
      if (reset) begin
        chk("addr_ok_rst", LAT, 32'(addr_ok[g]), 32'd0);
        chk("ram_en_rst", LAT, 32'(ram_en[g]), 32'd0);
        chk("ram_addr_rst", LAT, 32'(ram_addr[g]), 32'd0);
        chk("data_ok_rst", LAT, 32'(data_ok[g]), 32'd0);
        chk("rdata_rst", LAT, rdata[g], 32'd0);
        chk("busy_rst", LAT, 32'(busy[g]), 32'd0);
        q.delete();
      end else begin
        word = addr[13:2];
        eok  = req && (q.size() < DEPTH);
        edok = (q.size() > 0) && !hold && (q[0].ready <= cyc);
        chk("addr_ok", LAT, 32'(addr_ok[g]), 32'(eok));
        chk("ram_en", LAT, 32'(ram_en[g]), 32'(eok));
        chk("ram_addr", LAT, 32'(ram_addr[g]), 32'(word));
        chk("busy", LAT, 32'(busy[g]), 32'(q.size() != 0));
        chk("data_ok", LAT, 32'(data_ok[g]), 32'(edok));
        if (edok) begin
          chk("rdata", LAT, rdata[g], q[0].data);
          void'(q.pop_front());
        end
        if (eok) q.push_back('{data: mem[word], ready: cyc + LAT + 1});
      end
    end
  end

  initial begin
    int acc0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;
    reset = 1'b1; req = 1'b0; hold = 1'b0; addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single read to word 4 via an unaligned address with junk upper bits.
    req = 1'b1; addr = 32'h1000_0013;
    @(negedge clk);
    chk("lit_c0_addr_ok", 1, 32'(addr_ok), 32'h3);
    chk("lit_c0_ram_addr", 1, 32'(ram_addr[0]), 32'd4);
    chk("lit_c0_busy", 1, 32'(busy), 32'h0);
    step(); req = 1'b0;
    @(negedge clk);
    chk("lit_c1_data_ok", 1, 32'(data_ok), 32'h0);
    chk("lit_c1_busy", 1, 32'(busy), 32'h3);
    step(); @(negedge clk);
    chk("lit_c2_data_ok", 1, 32'(data_ok), 32'h1);
    chk("lit_c2_rdata", 1, rdata[0], 32'hDEADBEEF);
    step(); @(negedge clk);
    chk("lit_c3_data_ok", 1, 32'(data_ok), 32'h0);
    chk("lit_c3_busy", 1, 32'(busy), 32'h2);
    step(); @(negedge clk);
    chk("lit_c4_data_ok", 3, 32'(data_ok), 32'h2);
    chk("lit_c4_rdata", 3, rdata[1], 32'hDEADBEEF);
    step(); @(negedge clk);
    chk("lit_c5_busy", 3, 32'(busy), 32'h0);

    // Back-pressure: credits run out after DEPTH accepts.
    step();
    hold = 1'b1; req = 1'b1; addr = 32'h0; acc0 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc0 += int'(addr_ok[0]);
      step();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("lit_bp_accepts", 1, 32'(acc0), 32'd4);
    chk("lit_c10_addr_ok", 1, 32'(addr_ok), 32'h0);
    chk("lit_c10_data_ok", 1, 32'(data_ok), 32'h3);
    step(); @(negedge clk);
    chk("lit_c11_addr_ok", 1, 32'(addr_ok), 32'h3);
    step(); req = 1'b0;
    repeat (12) step();

    // Reset with requests outstanding in the pipe and buffer.
    req = 1'b1; addr = 32'h0000_0040;
    step(); addr = 32'h0000_0044;
    step(); req = 1'b0;
    step(); reset = 1'b1;
    step(); step(); reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("lit_post_rst_data_ok", 1, 32'(data_ok), 32'h0);
      step();
    end

    // Random traffic with occasional hold and reset.
    repeat (3000) begin
      req   = ($urandom_range(0, 9) < 7);
      addr  = $urandom;
      hold  = ($urandom_range(0, 9) < 3);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; req = 1'b0; hold = 1'b0;
    repeat (20) step();
    @(negedge clk);
    chk("lit_drained_busy", 1, 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
